lc3_exec_stage_hs: RTL
======================

// Module: lc3_exec_stage_hs
// PURPOSE
//  LC-3 execute stage with valid/ready handshakes, sitting between decode and memory.
//  Computes the ALU result, the branch/memory target pcout, store data, dr and NZP.
//  Parametrised data width and number of forwarding sources.
//  Adds an optional multi-cycle multiply on reserved opcode 4'b1101.
//  Applies backpressure (in_ready low) while the multiply runs or the output is stalled.
// PARAMETERS
//  DATA_W   16  datapath width; offsets and imm5 are sign-extended to DATA_W
//  NUM_FWD  2   number of forwarding sources (ALU, MEM, ...); FSEL_W = $clog2(NUM_FWD+1)
//  MUL_EN   1   1: opcode 1101 = multiply; 0: opcode 1101 is treated as a NOP
// PORTS
//  clk           in   1               clock
//  rst           in   1               synchronous, active-high reset
//  flush         in   1               synchronous kill of stage contents
//  in_valid      in   1               decode holds a valid instruction
//  in_ready      out  1               stage accepts this cycle
//  in_ir         in   16              instruction
//  in_npc        in   DATA_W          PC+1
//  in_e_ctrl     in   6               [5:4] alu_ctrl, [3:2] pcsel1, [1] pcsel2, [0] op2sel
//  in_w_ctrl     in   2               writeback control, passed through
//  in_mem_ctrl   in   1               memory control, passed through
//  in_vsr1       in   DATA_W          register-file value for sr1
//  in_vsr2       in   DATA_W          register-file value for sr2
//  fwd_sel1      in   FSEL_W          0 = in_vsr1; k = fwd_val slice k-1
//  fwd_sel2      in   FSEL_W          0 = in_vsr2; k = fwd_val slice k-1
//  fwd_val       in   NUM_FWD*DATA_W  packed forwarding values, slice 0 at LSBs
//  sr1           out  3               in_ir[8:6] (combinational)
//  sr2           out  3               ALU ops: ir[2:0]; ST/STR/STI: ir[11:9]; else 0 (combinational)
//  busy          out  1               multiply in progress
//  out_valid     out  1               output registers hold a result
//  out_ready     in   1               downstream accepts
//  out_aluout    out  DATA_W          ALU or multiply result
//  out_pcout     out  DATA_W          computed address
//  out_m_data    out  DATA_W          store data
//  out_dr        out  3               destination register
//  out_nzp       out  3               branch condition
//  out_ir        out  16              executed instruction
//  out_w_ctrl    out  2               passed-through writeback control
//  out_mem_ctrl  out  1               passed-through memory control
// BEHAVIOUR
//  - Reset: out_valid=0, busy=0, out_ir=16'h5020 (NOP), all other outputs 0, FSM=IDLE.
//  - Output skid: in_ready = (state==IDLE) && (!out_valid || out_ready). Accept on in_valid && in_ready.
//  - Single-cycle ops: result registered on the accept edge, so out_valid is high the next cycle (latency 1).
//    Output holds stable while out_valid && !out_ready.
//  - Output consumed with no new accept: out_valid=0 and out_nzp=0. No stale branch may be presented.
//  - src1 = fwd_sel1 mux. src2 = op2sel ? fwd_sel2 mux : imm5. Forwarding never overrides imm5.
//  - ALU: 00 ADD, 01 AND, 10 NOT src1, 11 PASS src1. All arithmetic is modulo 2^DATA_W.
//  - pcout = {off11, off9, off6, 0}[pcsel1] + (pcsel2 ? in_npc : src1). Uses the forwarded base.
//  - m_data = fwd_sel2 mux value for ST(0011), STR(0111), STI(1011); else 0.
//  - nzp = ir[11:9] for BR(0000); else 0.
//  - dr = ir[11:9] for ADD, AND, NOT, LD, LDR, LDI, LEA, MUL; else 0.
//  - FSM IDLE -> MUL on accepting opcode 1101 (MUL_EN=1). Operands are latched at accept.
//    Shift-add runs one bit per cycle for DATA_W cycles; busy=1 throughout.
//  - MUL -> DONE after the last bit; DONE loads the output register when it is free, then returns to IDLE.
//    Result = low DATA_W bits of src1*src2. Latency is DATA_W+1 cycles with no stall.
//  - flush: out_valid=0, out_nzp=0, out_ir=NOP, FSM -> IDLE, busy=0 next cycle.
//    flush beats a same-cycle accept; the accept is dropped.
//  - Reset mid-multiply aborts it; reset beats flush.
// STRUCTURE
//  - lc3_pkg: opcode localparams, NOP_IR=16'h5020, alu_ctrl_e enum, e_ctrl_t packed struct,
//    is_store()/writes_dr() functions.
//  - Sub-module lc3_iter_mul #(DATA_W): start/done, latched operands, one bit per cycle.
//  - Sign-extension is an inline function in lc3_pkg, parametrised by DATA_W.
// TESTING
//  1. Reset 2 cycles -> out_valid=0, out_ir=16'h5020, in_ready=1, busy=0.
//  2. ADD imm: IR=16'h12BD, vsr1=5, e_ctrl alu=00 op2sel=0 -> next cycle out_aluout=16'h0002, out_dr=1, out_valid=1.
//  3. Backpressure: out_ready=0 for 3 cycles with 2 queued instrs -> in_ready=0 after the first;
//     out_* stable; release yields both instrs in order, none lost or duplicated.
//  4. Forwarding: ADD reg, fwd_sel1=1, fwd_val[0]=16'h0010, vsr1=16'hFFFF, vsr2=1 -> out_aluout=16'h0011.
//     Same instr with op2sel=0 and fwd_sel2=2 -> imm5 is used.
//  5. MUL: IR op 1101, src1=7, src2=9 -> busy for 16 cycles, in_ready=0, out_aluout=63 at cycle 17.
//     Rerun with flush at cycle 5 -> busy=0 next cycle, no out_valid.
//  6. STR with fwd_sel2 giving 16'hBEEF -> out_m_data=16'hBEEF, sr2=ir[11:9].
//     BRz (IR=16'h0405) -> out_nzp=3'b010; after consumption with no new instr, out_nzp=0.

Source files
------------

// File: rtl/lc3_pkg.sv
// Shared LC-3 execute-stage definitions: opcodes, control encodings and small decode helpers.
package lc3_pkg;

    localparam logic [3:0] OP_BR   = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_LD   = 4'b0010;
    localparam logic [3:0] OP_ST   = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_LDR  = 4'b0110;
    localparam logic [3:0] OP_STR  = 4'b0111;
    localparam logic [3:0] OP_NOT  = 4'b1001;
    localparam logic [3:0] OP_LDI  = 4'b1010;
    localparam logic [3:0] OP_STI  = 4'b1011;
    localparam logic [3:0] OP_MUL  = 4'b1101;
    localparam logic [3:0] OP_LEA  = 4'b1110;

    localparam logic [15:0] NOP_IR = 16'h5020;

    typedef enum logic [1:0] {
        ALU_ADD  = 2'b00,
        ALU_AND  = 2'b01,
        ALU_NOT  = 2'b10,
        ALU_PASS = 2'b11
    } alu_ctrl_e;

    typedef struct packed {
        alu_ctrl_e  alu_ctrl;
        logic [1:0] pcsel1;
        logic       pcsel2;
        logic       op2sel;
    } e_ctrl_t;

    function automatic logic is_store(input logic [3:0] op);
        return (op == OP_ST) || (op == OP_STR) || (op == OP_STI);
    endfunction

    function automatic logic writes_dr(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_NOT) || (op == OP_LD) ||
               (op == OP_LDR) || (op == OP_LDI) || (op == OP_LEA) || (op == OP_MUL);
    endfunction

    function automatic logic alu_reads_sr2(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_MUL);
    endfunction

    // Replicates bit msb of val upward; callers cast the 32-bit result down to DATA_W (<= 32).
    function automatic logic [31:0] sext(input logic [15:0] val, input logic [3:0] msb);
        logic [31:0] r;
        r = 32'(val);
        for (int i = 0; i < 32; i++) begin
            if (i > int'(msb)) r[i] = val[msb];
        end
        return r;
    endfunction

endpackage

// File: rtl/lc3_iter_mul.sv
// Iterative shift-add multiplier: operands latched on start, one multiplier bit per cycle.
module lc3_iter_mul #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              abort,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              last,
    output logic [DATA_W-1:0] product
);
    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] a_reg, b_reg, acc_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              run_reg;

    // High during the cycle whose edge processes the final multiplier bit.
    assign last    = run_reg && (cnt_reg == CNT_W'(DATA_W - 1));
    assign product = acc_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg   <= '0;
            b_reg   <= '0;
            acc_reg <= '0;
            cnt_reg <= '0;
            run_reg <= 1'b0;
        end else if (abort) begin
            run_reg <= 1'b0;
            cnt_reg <= '0;
        end else if (start) begin
            a_reg   <= a;
            b_reg   <= b;
            acc_reg <= '0;
            cnt_reg <= '0;
            run_reg <= 1'b1;
        end else if (run_reg) begin
            if (b_reg[0]) acc_reg <= acc_reg + a_reg;
            a_reg   <= a_reg << 1;
            b_reg   <= b_reg >> 1;
            cnt_reg <= cnt_reg + 1'b1;
            if (last) run_reg <= 1'b0;
        end
    end

endmodule

// File: rtl/lc3_exec_stage_hs.sv
// LC-3 execute stage with valid/ready handshakes on both sides and an optional iterative multiply.
module lc3_exec_stage_hs
    import lc3_pkg::*;
#(
    parameter int  DATA_W  = 16,
    parameter int  NUM_FWD = 2,
    parameter bit  MUL_EN  = 1'b1,
    localparam int FSEL_W  = $clog2(NUM_FWD + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [15:0]               in_ir,
    input  logic [DATA_W-1:0]         in_npc,
    input  logic [5:0]                in_e_ctrl,
    input  logic [1:0]                in_w_ctrl,
    input  logic                      in_mem_ctrl,
    input  logic [DATA_W-1:0]         in_vsr1,
    input  logic [DATA_W-1:0]         in_vsr2,
    input  logic [FSEL_W-1:0]         fwd_sel1,
    input  logic [FSEL_W-1:0]         fwd_sel2,
    input  logic [NUM_FWD*DATA_W-1:0] fwd_val,
    output logic [2:0]                sr1,
    output logic [2:0]                sr2,
    output logic                      busy,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_aluout,
    output logic [DATA_W-1:0]         out_pcout,
    output logic [DATA_W-1:0]         out_m_data,
    output logic [2:0]                out_dr,
    output logic [2:0]                out_nzp,
    output logic [15:0]               out_ir,
    output logic [1:0]                out_w_ctrl,
    output logic                      out_mem_ctrl
);
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_e;

    typedef struct packed {
        logic [DATA_W-1:0] aluout;
        logic [DATA_W-1:0] pcout;
        logic [DATA_W-1:0] m_data;
        logic [2:0]        dr;
        logic [2:0]        nzp;
        logic [15:0]       ir;
        logic [1:0]        w_ctrl;
        logic              mem_ctrl;
    } res_t;

    state_e            state_reg;
    res_t              out_reg, pend_reg, cur;
    logic              out_valid_reg;
    e_ctrl_t           ectrl;
    logic [3:0]        opcode;
    logic [DATA_W-1:0] fwd_arr [NUM_FWD];
    logic [DATA_W-1:0] src1, src2, fwd2, imm5, addr1, addr2, alu_res, mul_product;
    logic              accept, is_mul, mul_start, mul_last;

    assign ectrl  = e_ctrl_t'(in_e_ctrl);
    assign opcode = in_ir[15:12];
    assign imm5   = DATA_W'(sext(in_ir, 4'd4));

    generate
        for (genvar gi = 0; gi < NUM_FWD; gi++) begin : g_fwd
            assign fwd_arr[gi] = fwd_val[gi*DATA_W +: DATA_W];
        end
    endgenerate

    always_comb begin
        src1 = in_vsr1;
        fwd2 = in_vsr2;
        for (int k = 0; k < NUM_FWD; k++) begin
            if (fwd_sel1 == FSEL_W'(k + 1)) src1 = fwd_arr[k];
            if (fwd_sel2 == FSEL_W'(k + 1)) fwd2 = fwd_arr[k];
        end
    end

    // Forwarding feeds src2 only in register mode; an immediate operand is never overridden.
    always_comb begin
        src2 = ectrl.op2sel ? fwd2 : imm5;
        case (ectrl.pcsel1)
            2'd0:    addr1 = DATA_W'(sext(in_ir, 4'd10));
            2'd1:    addr1 = DATA_W'(sext(in_ir, 4'd8));
            2'd2:    addr1 = DATA_W'(sext(in_ir, 4'd5));
            default: addr1 = '0;
        endcase
        addr2 = ectrl.pcsel2 ? in_npc : src1;
        case (ectrl.alu_ctrl)
            ALU_ADD: alu_res = src1 + src2;
            ALU_AND: alu_res = src1 & src2;
            ALU_NOT: alu_res = ~src1;
            default: alu_res = src1;
        endcase
        cur          = '0;
        cur.aluout   = alu_res;
        cur.pcout    = addr1 + addr2;
        cur.m_data   = is_store(opcode) ? fwd2 : '0;
        cur.dr       = writes_dr(opcode) ? in_ir[11:9] : 3'd0;
        cur.nzp      = (opcode == OP_BR) ? in_ir[11:9] : 3'd0;
        cur.ir       = in_ir;
        cur.w_ctrl   = in_w_ctrl;
        cur.mem_ctrl = in_mem_ctrl;
        if (opcode == OP_MUL && !MUL_EN) begin
            cur    = '0;
            cur.ir = NOP_IR;
        end
    end

    assign sr1       = in_ir[8:6];
    assign sr2       = alu_reads_sr2(opcode) ? in_ir[2:0] : (is_store(opcode) ? in_ir[11:9] : 3'd0);
    assign in_ready  = (state_reg == S_IDLE) && (!out_valid_reg || out_ready);
    assign accept    = in_valid && in_ready;
    assign is_mul    = MUL_EN && (opcode == OP_MUL);
    assign mul_start = accept && is_mul && !flush;
    assign busy      = (state_reg == S_MUL);

    lc3_iter_mul #(.DATA_W(DATA_W)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .abort   (flush),
        .start   (mul_start),
        .a       (src1),
        .b       (src2),
        .last    (mul_last),
        .product (mul_product)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            out_valid_reg <= 1'b0;
            out_reg       <= '0;
            out_reg.ir    <= NOP_IR;
            pend_reg      <= '0;
        end else if (flush) begin
            state_reg     <= S_IDLE;
            out_valid_reg <= 1'b0;
            out_reg.nzp   <= 3'd0;
            out_reg.ir    <= NOP_IR;
        end else begin
            // A consumed result with nothing new behind it must not leave a branch condition visible.
            if (out_valid_reg && out_ready) begin
                out_valid_reg <= 1'b0;
                out_reg.nzp   <= 3'd0;
            end
            case (state_reg)
                S_IDLE: begin
                    if (accept && is_mul) begin
                        pend_reg  <= cur;
                        state_reg <= S_MUL;
                    end else if (accept) begin
                        out_reg       <= cur;
                        out_valid_reg <= 1'b1;
                    end
                end
                S_MUL: begin
                    if (mul_last) state_reg <= S_DONE;
                end
                default: begin
                    if (!out_valid_reg || out_ready) begin
                        out_reg        <= pend_reg;
                        out_reg.aluout <= mul_product;
                        out_valid_reg  <= 1'b1;
                        state_reg      <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign out_valid    = out_valid_reg;
    assign out_aluout   = out_reg.aluout;
    assign out_pcout    = out_reg.pcout;
    assign out_m_data   = out_reg.m_data;
    assign out_dr       = out_reg.dr;
    assign out_nzp      = out_reg.nzp;
    assign out_ir       = out_reg.ir;
    assign out_w_ctrl   = out_reg.w_ctrl;
    assign out_mem_ctrl = out_reg.mem_ctrl;

endmodule
